// File: rtl/maxpool2_ctrl.sv
// Sequences a 2x2/stride-2 max-pool over one SRAM-resident feature map, raster order.
// Latency: 6 cycles per output window (4 reads, 1 data wait, 1 write); start and done add 1 cycle each.
// Backpressure: WRITE holds wr_en/wr_addr/wr_data and pool_win until wr_ready; nothing else stalls.
// Build option MAXPOOL2_CTRL_PERF_EN enables the busy-cycle counter on cycle_count (tied to 0 otherwise).
module maxpool2_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   cfg_in_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_out_base,
  input  logic [DIM_WIDTH-1:0]    cfg_width,
  input  logic [DIM_WIDTH-1:0]    cfg_height,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [4*DATA_WIDTH-1:0] pool_win,
  input  logic [DATA_WIDTH-1:0]   pool_max,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_ready,
  output logic [31:0]             cycle_count
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  state_t                state;
  logic [1:0]            k;         // read index within the current window
  logic [DIM_WIDTH-1:0]  w_q;       // sampled input width
  logic [DIM_WIDTH-1:0]  ow;        // output columns
  logic [DIM_WIDTH-1:0]  oh;        // output rows
  logic [DIM_WIDTH-1:0]  r;         // current output row
  logic [DIM_WIDTH-1:0]  c;         // current output column
  logic [ADDR_WIDTH-1:0] row_base;  // in_base + 2*r*W, kept incrementally to avoid a multiplier
  logic [ADDR_WIDTH-1:0] col_off;   // 2*c
  logic [DIM_WIDTH-1:0]  start_ow;
  logic [DIM_WIDTH-1:0]  start_oh;
  logic [ADDR_WIDTH-1:0] w_ext;
  logic [ADDR_WIDTH-1:0] row_step;
  logic [ADDR_WIDTH-1:0] next_rd_addr;
  logic [1:0]            kn;
  logic                  last_col;
  logic                  last_win;

  assign start_ow = cfg_width >> 1;
  assign start_oh = cfg_height >> 1;
  assign w_ext    = ADDR_WIDTH'(w_q);
  assign row_step = w_ext << 1;
  assign last_col = (c == ow - DIM_ONE);
  assign last_win = last_col && (r == oh - DIM_ONE);
  assign wr_data  = pool_max;

  // address of read k+1 inside the current window: dy selects +W, dx selects +1
  always_comb begin
    kn           = k + 2'd1;
    next_rd_addr = row_base + col_off + ADDR_WIDTH'(kn[0]);
    if (kn[1]) next_rd_addr = next_rd_addr + w_ext;
  end

  // window sequencer: four reads, one wait for the last read data, then write the max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      w_q      <= '0;
      ow       <= '0;
      oh       <= '0;
      r        <= '0;
      c        <= '0;
      row_base <= '0;
      col_off  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      pool_win <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_q      <= cfg_width;
            ow       <= start_ow;
            oh       <= start_oh;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            row_base <= cfg_in_base;
            col_off  <= '0;
            wr_addr  <= cfg_out_base;
            if (start_ow == '0 || start_oh == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= READ;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= cfg_in_base;
            end
          end
        end
        READ: begin
          // data for read k-1 arrives this cycle
          for (int i = 0; i < 3; i++) begin
            if (k == 2'(i + 1)) pool_win[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
          end
          if (k == 2'd3) begin
            state <= WAIT;
            rd_en <= 1'b0;
          end else begin
            k       <= kn;
            rd_addr <= next_rd_addr;
          end
        end
        WAIT: begin
          pool_win[3*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
          state <= WRITE;
          wr_en <= 1'b1;
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_win) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= READ;
              k       <= '0;
              rd_en   <= 1'b1;
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
              if (last_col) begin
                c        <= '0;
                r        <= r + DIM_ONE;
                col_off  <= '0;
                row_base <= row_base + row_step;
                rd_addr  <= row_base + row_step;
              end else begin
                c       <= c + DIM_ONE;
                col_off <= col_off + ADDR_WIDTH'(2);
                rd_addr <= row_base + col_off + ADDR_WIDTH'(2);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAXPOOL2_CTRL_PERF_EN
  // busy-cycle counter: cleared by an accepted start, saturates at all-ones, holds after done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (state == IDLE && start) begin
      cycle_count <= '0;
    end else if (busy && cycle_count != '1) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_maxpool2_ctrl.sv
// Directed bench for maxpool2_ctrl with an SRAM model and a combinational maxpool2 model.
// Latency is measured between the edge that samples start and the edge that samples done.
// Inputs change on the falling edge; outputs are observed on the falling edge or at sampling edges.
module tb_maxpool2_ctrl;
`ifdef MAXPOOL2_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_in_base;
  logic [15:0] cfg_out_base;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_height;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [31:0] pool_win;
  logic [7:0]  pool_max;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [31:0] cycle_count;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [15:0] exp_r[$];
  logic [15:0] exp_a[$];
  logic [7:0]  exp_d[$];

  maxpool2_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_win(pool_win), .pool_max(pool_max),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM: data valid the cycle after the strobe
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [7:0] max4(input logic [31:0] win);
    logic [7:0] m;
    m = win[7:0];
    for (int i = 1; i < 4; i++) if (win[i*8 +: 8] > m) m = win[i*8 +: 8];
    return m;
  endfunction

  assign pool_max = max4(pool_win);

  // record timing, reads and accepted writes at each sampling edge
  always @(posedge clk) begin
    cyc++;
    if (start && !busy && !done && !rst) start_cyc = cyc;
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (rd_en) rd_q.push_back(rd_addr);
    if (wr_en && wr_ready) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  function automatic logic [31:0] perf_exp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] ib, input logic [15:0] ob,
                             input logic [7:0] w, input logic [7:0] h);
    cfg_in_base  = ib;
    cfg_out_base = ob;
    cfg_width    = w;
    cfg_height   = h;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, " write count"}, wa_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("%s wr_addr[%0d]", tag, i), 32'(wa_q[i]), 32'(exp_a[i]));
        check($sformatf("%s wr_data[%0d]", tag, i), 32'(wd_q[i]), 32'(exp_d[i]));
      end
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, " read count"}, rd_q.size(), exp_r.size());
    for (int i = 0; i < exp_r.size(); i++) begin
      if (i < rd_q.size()) check($sformatf("%s rd_addr[%0d]", tag, i), 32'(rd_q[i]), 32'(exp_r[i]));
    end
  endtask

  // start launched one edge before it is sampled: 1+6N+1 edges from launch is 6N+1 here
  task automatic check_timing(input string tag, input int exp_lat);
    check({tag, " latency"}, 32'(done_cyc - start_cyc), 32'(exp_lat));
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    start        = 1'b0;
    cfg_in_base  = '0;
    cfg_out_base = '0;
    cfg_width    = '0;
    cfg_height   = '0;
    wr_ready     = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'd0;

    // reset state
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rd_en", 32'(rd_en), 32'd0);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst rd_addr", 32'(rd_addr), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst pool_win", pool_win, 32'd0);
    check("rst cycle_count", cycle_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // A: 4x4 map 0..15, wr_ready high
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 8'(i);
    clear_logs();
    pulse_start(16'h0100, 16'h0200, 8'd4, 8'd4);
    wait_done("A", 60);
    check("A cycle_count", cycle_count, perf_exp(24));
    @(negedge clk);
    check_timing("A", 25);
    check("A read count", rd_q.size(), 16);
    exp_a = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    exp_d = '{8'd5, 8'd7, 8'd13, 8'd15};
    check_writes("A");
    check("A pool_win held", pool_win, 32'h0F0E0B0A);

    // B: same map, first write stalled for 3 cycles
    clear_logs();
    wr_ready = 1'b0;
    pulse_start(16'h0100, 16'h0200, 8'd4, 8'd4);
    n = 0;
    while (wr_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("B stall%0d wr_en", i), 32'(wr_en), 32'd1);
      check($sformatf("B stall%0d wr_addr", i), 32'(wr_addr), 32'h0200);
      check($sformatf("B stall%0d wr_data", i), 32'(wr_data), 32'd5);
      @(negedge clk);
    end
    wr_ready = 1'b1;
    wait_done("B", 60);
    check("B cycle_count", cycle_count, perf_exp(27));
    @(negedge clk);
    check_timing("B", 28);
    check_writes("B");

    // C: 5x3 map 0..14, cfg changed and start re-pulsed mid-job
    for (int i = 0; i < 15; i++) mem[16'h0300 + i] = 8'(i);
    clear_logs();
    pulse_start(16'h0300, 16'h0400, 8'd5, 8'd3);
    cfg_in_base = 16'hAAAA;
    cfg_width   = 8'd4;
    cfg_height  = 8'd4;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("C", 40);
    @(negedge clk);
    check_timing("C", 13);
    exp_r = '{16'h0300, 16'h0301, 16'h0305, 16'h0306, 16'h0302, 16'h0303, 16'h0307, 16'h0308};
    check_reads("C");
    exp_a = '{16'h0400, 16'h0401};
    exp_d = '{8'd6, 8'd8};
    check_writes("C");

    // D: W=1 gives an empty output map
    clear_logs();
    pulse_start(16'h0100, 16'h0600, 8'd1, 8'd8);
    wait_done("D", 10);
    check("D cycle_count", cycle_count, 32'd0);
    @(negedge clk);
    check_timing("D", 1);
    check("D read count", rd_q.size(), 0);
    check("D write count", wa_q.size(), 0);

    // E: read addresses wrap past the top of the address space
    mem[16'hFFFE] = 8'd200;
    mem[16'hFFFF] = 8'd17;
    mem[16'h0000] = 8'd255;
    mem[16'h0001] = 8'd3;
    clear_logs();
    pulse_start(16'hFFFE, 16'h0500, 8'd2, 8'd2);
    wait_done("E", 20);
    @(negedge clk);
    check_timing("E", 7);
    exp_r = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check_reads("E");
    exp_a = '{16'h0500};
    exp_d = '{8'd255};
    check_writes("E");

    // F: reset during the second window's reads, then a clean rerun
    clear_logs();
    pulse_start(16'h0100, 16'h0200, 8'd4, 8'd4);
    n = 0;
    while (!(rd_en === 1'b1 && rd_addr === 16'h0102) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("F reached window 2", 32'(rd_addr), 32'h0102);
    rst = 1'b1;
    #1;
    check("F rst busy", 32'(busy), 32'd0);
    check("F rst done", 32'(done), 32'd0);
    check("F rst rd_en", 32'(rd_en), 32'd0);
    check("F rst wr_en", 32'(wr_en), 32'd0);
    check("F rst rd_addr", 32'(rd_addr), 32'd0);
    check("F rst wr_addr", 32'(wr_addr), 32'd0);
    check("F rst pool_win", pool_win, 32'd0);
    check("F rst cycle_count", cycle_count, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("F no done after abort", 32'(done_cnt), 32'd0);
    clear_logs();
    pulse_start(16'h0100, 16'h0200, 8'd4, 8'd4);
    wait_done("F", 60);
    check("F cycle_count", cycle_count, perf_exp(24));
    @(negedge clk);
    check_timing("F", 25);
    exp_a = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
    exp_d = '{8'd5, 8'd7, 8'd13, 8'd15};
    check_writes("F");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
